// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered, flow-controlled immediate-decode stage between fetch and
//   register read. Each accepted instruction is decoded combinationally and
//   captured together with its decoded fields into a 2-entry buffer. The
//   buffer has a main register and a skid register and is drained in FIFO
//   order.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush                drop all buffered entries (branch redirect)
//   in_valid/in_ready    upstream handshake; in_ready comes from a register only
//   in_instr, in_pc      instruction word and its PC tag
//   out_valid/out_ready  downstream handshake
//   out_instr, out_pc    passed through unchanged
//   out_imm              decoded immediate (XLEN wide)
//   out_imm_type         0 NONE,1 I,2 S,3 B,4 U,5 J,6 Z,7 SH
//   out_illegal          opcode not recognised (the entry still flows)
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    localparam logic IS64 = (XLEN == 64);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;
    localparam logic [2:0] T_SH   = 3'd7;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      ty;
        logic            ill;
    } entry_t;

    // Sign-extend a 32-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // funct3 001 (sll) and 101 (srl/sra) select the shift-amount form.
    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    entry_t     dec_s;
    entry_t     main_r;
    entry_t     skid_r;
    logic       main_valid_r;
    logic       skid_valid_r;
    logic       main_free_s;
    logic       accept_s;
    logic [6:0] op_s;
    logic [2:0] f3_s;

    assign op_s = in_instr[6:0];
    assign f3_s = in_instr[14:12];

    // Immediate decode of the incoming instruction word.
    always_comb begin
        dec_s.instr = in_instr;
        dec_s.pc    = in_pc;
        dec_s.imm   = {XLEN{1'b0}};
        dec_s.ty    = T_NONE;
        dec_s.ill   = 1'b0;
        case (op_s)
            OPC_OP_IMM: begin
                if (is_shift(f3_s)) begin
                    dec_s.ty = T_SH;
                    // bit 30 (arithmetic select) is never part of the amount
                    if (IS64) begin
                        dec_s.imm = XLEN'(in_instr[25:20]);
                    end else begin
                        dec_s.imm = XLEN'(in_instr[24:20]);
                    end
                end else begin
                    dec_s.ty  = T_I;
                    dec_s.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
                end
            end
            OPC_OP_IMM32: begin
                if (!IS64) begin
                    dec_s.ill = 1'b1;
                end else if (is_shift(f3_s)) begin
                    dec_s.ty  = T_SH;
                    dec_s.imm = XLEN'(in_instr[24:20]);
                end else begin
                    dec_s.ty  = T_I;
                    dec_s.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec_s.ty  = T_I;
                dec_s.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            end
            OPC_STORE: begin
                dec_s.ty  = T_S;
                dec_s.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            end
            OPC_BRANCH: begin
                dec_s.ty  = T_B;
                dec_s.imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                    in_instr[30:25], in_instr[11:8], 1'b0});
            end
            OPC_JAL: begin
                dec_s.ty  = T_J;
                dec_s.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                    in_instr[20], in_instr[30:21], 1'b0});
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_s.ty  = T_U;
                dec_s.imm = sext32({in_instr[31:12], 12'b0});
            end
            OPC_SYSTEM: begin
                // only the immediate CSR forms (funct3 101/110/111) carry a zimm
                if (f3_s[2] && (f3_s[1:0] != 2'b00)) begin
                    dec_s.ty  = T_Z;
                    dec_s.imm = XLEN'(in_instr[19:15]);
                end else begin
                    dec_s.ty  = T_NONE;
                end
            end
            OPC_OP, OPC_FENCE: begin
                dec_s.ty = T_NONE;
            end
            OPC_OP32: begin
                if (IS64) begin
                    dec_s.ill = 1'b0;
                end else begin
                    dec_s.ill = 1'b1;
                end
            end
            default: begin
                dec_s.ill = 1'b1;
            end
        endcase
    end

    // in_ready depends only on the skid register, never on out_ready.
    assign in_ready    = ~skid_valid_r;
    assign accept_s    = in_valid & ~skid_valid_r;
    // main can take a new occupant when empty or being consumed this cycle
    assign main_free_s = ~main_valid_r | out_ready;

    // Main/skid buffer update with rst > flush > normal priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_r       <= '{default: '0};
            skid_r       <= '{default: '0};
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (main_free_s) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                main_r       <= dec_s;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end
    end

    assign out_valid    = main_valid_r;
    assign out_instr    = main_r.instr;
    assign out_pc       = main_r.pc;
    assign out_imm      = main_r.imm;
    assign out_imm_type = main_r.ty;
    assign out_illegal  = main_r.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: an RV32 and an RV64 instance share all inputs. The driver
// pushes expectations from a behavioural decode model on every accept; the
// monitor compares the head of the queue whenever an output is presented.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [63:0] in_pc = 64'd0;
    logic        out_ready = 1'b0;

    logic        ir32, ov32, oil32;
    logic [31:0] oi32, opc32, oimm32;
    logic [2:0]  ot32;
    logic        ir64, ov64, oil64;
    logic [31:0] oi64;
    logic [63:0] opc64, oimm64;
    logic [2:0]  ot64;

    int checks = 0;
    int failures = 0;
    bit mdl_ready = 1'b1;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  t32;
        logic [2:0]  t64;
        logic        i32;
        logic        i64;
    } exp_t;

    exp_t q[$];

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .out_instr(oi32), .out_pc(opc32), .out_imm(oimm32), .out_imm_type(ot32),
        .out_illegal(oil32)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
        .out_instr(oi64), .out_pc(opc64), .out_imm(oimm64), .out_imm_type(ot64),
        .out_illegal(oil64)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
        end
    endfunction

    // Reference decode using field arithmetic on signed integers.
    function automatic void ref_dec(input logic [31:0] ins, input bit is64,
                                    output logic [63:0] imm, output logic [2:0] ty,
                                    output logic ill);
        longint v = 0;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        bit sh = (f3 == 3'd1) || (f3 == 3'd5);
        longint iv = longint'(ins[30:20]) - (ins[31] ? 64'sd2048 : 64'sd0);
        ty = 3'd0;
        ill = 1'b0;
        case (op)
            7'h13: if (sh) begin ty = 3'd7; v = is64 ? longint'(ins[25:20]) : longint'(ins[24:20]); end
                   else begin ty = 3'd1; v = iv; end
            7'h1B: if (!is64) ill = 1'b1;
                   else if (sh) begin ty = 3'd7; v = longint'(ins[24:20]); end
                   else begin ty = 3'd1; v = iv; end
            7'h03, 7'h67: begin ty = 3'd1; v = iv; end
            7'h23: begin ty = 3'd2;
                v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 64'sd2048 : 64'sd0); end
            7'h63: begin ty = 3'd3;
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
                    - (ins[31] ? 64'sd4096 : 64'sd0); end
            7'h6F: begin ty = 3'd5;
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
                    - (ins[31] ? 64'sd1048576 : 64'sd0); end
            7'h37, 7'h17: begin ty = 3'd4;
                v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sd4294967296 : 64'sd0); end
            7'h73: if (f3 >= 3'd5) begin ty = 3'd6; v = longint'(ins[19:15]); end
            7'h33, 7'h0F: ty = 3'd0;
            7'h3B: ill = !is64;
            default: ill = 1'b1;
        endcase
        imm = v;
    endfunction

    // Drive one cycle of inputs; record the expectation if the model says it is accepted.
    task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, input bit r);
        exp_t e;
        logic [63:0] imm;
        @(posedge clk);
        #1;
        in_valid = v; in_instr = ins; in_pc = {$urandom, $urandom};
        out_ready = ordy; flush = fl; rst = r;
        @(negedge clk);
        #1;
        if (v && mdl_ready && !fl && !r) begin
            e.instr = ins;
            e.pc = in_pc;
            ref_dec(ins, 1'b0, imm, e.t32, e.i32);
            e.imm32 = {32'd0, imm[31:0]};
            ref_dec(ins, 1'b1, e.imm64, e.t64, e.i64);
            q.push_back(e);
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_imm32"}, {32'd0, oimm32}, 64'd0);
        chk({n, "_pc32"}, {32'd0, opc32}, 64'd0);
        chk({n, "_instr32"}, {32'd0, oi32}, 64'd0);
        chk({n, "_type32"}, {61'd0, ot32}, 64'd0);
        chk({n, "_ill32"}, {63'd0, oil32}, 64'd0);
        chk({n, "_imm64"}, oimm64, 64'd0);
        chk({n, "_pc64"}, opc64, 64'd0);
        chk({n, "_type64"}, {61'd0, ot64}, 64'd0);
    endtask

    // Monitor: handshake vs model occupancy, head-of-queue field compare, pop on consume.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            mdl_ready = 1'b1;
        end else begin
            mdl_ready = (q.size() < 2);
            chk("in_ready32", {63'd0, ir32}, {63'd0, mdl_ready});
            chk("in_ready64", {63'd0, ir64}, {63'd0, mdl_ready});
            chk("out_valid32", {63'd0, ov32}, {63'd0, q.size() != 0});
            chk("out_valid64", {63'd0, ov64}, {63'd0, q.size() != 0});
            if (q.size() != 0) begin
                e = q[0];
                if (ov32) begin
                    chk("instr32", {32'd0, oi32}, {32'd0, e.instr});
                    chk("pc32", {32'd0, opc32}, {32'd0, e.pc[31:0]});
                    chk("imm32", {32'd0, oimm32}, e.imm32);
                    chk("type32", {61'd0, ot32}, {61'd0, e.t32});
                    chk("ill32", {63'd0, oil32}, {63'd0, e.i32});
                end
                if (ov64) begin
                    chk("instr64", {32'd0, oi64}, {32'd0, e.instr});
                    chk("pc64", opc64, e.pc);
                    chk("imm64", oimm64, e.imm64);
                    chk("type64", {61'd0, ot64}, {61'd0, e.t64});
                    chk("ill64", {63'd0, oil64}, {63'd0, e.i64});
                end
                if (out_ready) q.pop_front();
            end
            if (flush) q.delete();
        end
    end

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [13] = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                                 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F, 7'h3B};
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 12)]};
    endfunction

    logic [31:0] vecs [14] = '{32'hFFF00093, 32'hFE112E23, 32'hABCDE2B7, 32'h4030D093,
                               32'h3002D073, 32'h00000000, 32'h03F09093, 32'h0000009B,
                               32'hFE0008E3, 32'h800000EF, 32'h0000700F, 32'h00301073,
                               32'h7FFFF017, 32'h0000003B};

    initial begin
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk_zero("reset");

        // Directed decode vectors at full throughput.
        foreach (vecs[i]) drive(1'b1, vecs[i], 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A and B buffered, C refused until space frees up.
        drive(1'b1, 32'hFFF00093, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hFE112E23, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hABCDE2B7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hABCDE2B7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Flush with both entries full and a valid input pending.
        drive(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00100013, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00200013, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_out_valid", {63'd0, ov32}, 64'd0);
        chk("flush_in_ready", {63'd0, ir64}, 64'd1);

        // Reset mid-stream: same effect, and fields return to zero.
        drive(1'b1, 32'h00300013, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00400013, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00500013, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("rst_out_valid", {63'd0, ov64}, 64'd0);
        chk("rst_in_ready", {63'd0, ir32}, 64'd1);
        chk_zero("midrst");

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
